// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the 74181 slice and its multi-cycle sequencer.
//   seq_state_t  : sequencer FSM states
//   S_*          : named 74181 function selects
//   CARRY/NO_CARRY : active-low carry polarity
//   count_width(): width of the nibble counter (minimum 1 bit)
// -----------------------------------------------------------------------------
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Arithmetic selects assume m=0; S_XOR is the same code used with m=1.
    localparam logic [3:0] S_A_PLUS_1  = 4'b0000;
    localparam logic [3:0] S_A_MINUS_B = 4'b0110;
    localparam logic [3:0] S_A_PLUS_B  = 4'b1001;
    localparam logic [3:0] S_XOR       = 4'b0110;
    localparam logic [3:0] S_A_MINUS_1 = 4'b1111;

    // The 74181 carry pins are active-low.
    localparam logic CARRY    = 1'b0;
    localparam logic NO_CARRY = 1'b1;

    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ula_74181.sv
// -----------------------------------------------------------------------------
// ula_74181
// Combinational model of one 74181 4-bit ALU slice, active-high data.
//   a, b    : 4-bit operands
//   s       : function select
//   m       : 1 = logic, 0 = arithmetic
//   c_in    : carry in, active-low (0 = carry)
//   f       : 4-bit result
//   c_out   : carry out, active-low; computed from the arithmetic path in
//             both modes, as on the real part
//   a_eq_b  : high when f is all ones
// -----------------------------------------------------------------------------
module ula_74181
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [3:0] op_x;
    logic [3:0] op_y;
    logic [4:0] sum;

    // Every arithmetic function of the part is op_x plus op_y plus carry,
    // where s[1:0] builds op_x from A|B terms and s[3:2] builds op_y from
    // A&B terms. The logic functions are the XNOR of the same two terms.
    assign op_x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign op_y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

    assign sum    = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, ~c_in};
    assign f      = m ? ~(op_x ^ op_y) : sum[3:0];
    assign c_out  = ~sum[4];
    assign a_eq_b = &f;

endmodule

// File: rtl/ula_74181_seq.sv
// -----------------------------------------------------------------------------
// ula_74181_seq
// Runs one 74181 function on NIBBLES x 4-bit operands through a single shared
// slice, one nibble per clock, LSB nibble first, carry rippled via a register.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start           : request, sampled only in IDLE
//   a, b, s, m, c_in: operands and function, captured on accepted start
//   busy            : high in RUN and DONE
//   done            : one-cycle pulse, result valid
//   f               : W-bit result, held until overwritten by the next result
//   c_out           : carry out of the top nibble, active-low
//   a_eq_b          : AND of the per-nibble a_eq_b outputs
// -----------------------------------------------------------------------------
module ula_74181_seq
    import ula_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [3:0]             s,
    input  logic                   m,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   f,
    output logic                   c_out,
    output logic                   a_eq_b
);

    localparam int              W      = 4 * NIBBLES;
    localparam int              KW     = count_width(NIBBLES);
    localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic [KW-1:0] k;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [3:0]    s_reg;
    logic          m_reg;
    logic          carry_reg;
    logic          eq_reg;
    logic [W-1:0]  res_reg;
    logic [W-1:0]  res_next;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    alu_f;
    logic          alu_c_out;
    logic          alu_eq;

    // Select operand nibble k for the shared slice.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == KW'(i)) begin
                nib_a = a_reg[4*i +: 4];
                nib_b = b_reg[4*i +: 4];
            end
        end
    end

    // Result with nibble k replaced by the slice output; kept separate from
    // the operand mux so the block does not read its own downstream logic.
    always_comb begin
        res_next = res_reg;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == KW'(i)) begin
                res_next[4*i +: 4] = alu_f;
            end
        end
    end

    ula_74181 u_slice (
        .a      (nib_a),
        .b      (nib_b),
        .s      (s_reg),
        .m      (m_reg),
        .c_in   (carry_reg),
        .f      (alu_f),
        .c_out  (alu_c_out),
        .a_eq_b (alu_eq)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, nibble chain and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            carry_reg <= NO_CARRY;
            eq_reg    <= 1'b1;
            res_reg   <= '0;
            f         <= '0;
            c_out     <= NO_CARRY;
            a_eq_b    <= 1'b0;
        end else if (state == IDLE && start) begin
            k         <= '0;
            a_reg     <= a;
            b_reg     <= b;
            s_reg     <= s;
            m_reg     <= m;
            carry_reg <= c_in;
            eq_reg    <= 1'b1;
            res_reg   <= '0;
        end else if (state == RUN) begin
            res_reg   <= res_next;
            carry_reg <= alu_c_out;
            eq_reg    <= eq_reg & alu_eq;
            k         <= k + 1'b1;
            // The last nibble goes straight to the outputs so they are valid
            // in the same cycle that done is raised.
            if (k == K_LAST) begin
                k      <= '0;
                f      <= res_next;
                c_out  <= alu_c_out;
                a_eq_b <= eq_reg & alu_eq;
            end
        end
    end

endmodule

// File: tb/tb_ula_74181_seq.sv
// -----------------------------------------------------------------------------
// tb_ula_74181_seq
// Self-checking bench for ula_74181_seq with NIBBLES=4. The reference model
// evaluates each 74181 function over the full 16-bit width in one step.
// -----------------------------------------------------------------------------
module tb_ula_74181_seq;
    import ula_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c_out;
        logic         eq;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic         c_out;
    logic         a_eq_b;

    int vectors     = 0;
    int miscompares = 0;

    ula_74181_seq #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .f      (f),
        .c_out  (c_out),
        .a_eq_b (a_eq_b)
    );

    always #5 clk = ~clk;

    // Datasheet function table applied to the whole word.
    function automatic res_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                       input logic [3:0] rs, input logic rm, input logic rc);
        logic [W:0]   za;
        logic [W:0]   ones;
        logic [W:0]   sum;
        logic [W-1:0] lf;
        res_t         r;
        za   = {1'b0, ra};
        ones = {1'b0, {W{1'b1}}};
        case (rs)
            4'h0: sum = za;
            4'h1: sum = {1'b0, ra | rb};
            4'h2: sum = {1'b0, ra | ~rb};
            4'h3: sum = ones;
            4'h4: sum = za + {1'b0, ra & ~rb};
            4'h5: sum = {1'b0, ra | rb} + {1'b0, ra & ~rb};
            4'h6: sum = za + {1'b0, ~rb};
            4'h7: sum = {1'b0, ra & ~rb} + ones;
            4'h8: sum = za + {1'b0, ra & rb};
            4'h9: sum = za + {1'b0, rb};
            4'hA: sum = {1'b0, ra | ~rb} + {1'b0, ra & rb};
            4'hB: sum = {1'b0, ra & rb} + ones;
            4'hC: sum = za + za;
            4'hD: sum = {1'b0, ra | rb} + za;
            4'hE: sum = {1'b0, ra | ~rb} + za;
            default: sum = za + ones;
        endcase
        if (rc == CARRY) sum = sum + 1'b1;
        case (rs)
            4'h0: lf = ~ra;
            4'h1: lf = ~(ra | rb);
            4'h2: lf = ~ra & rb;
            4'h3: lf = '0;
            4'h4: lf = ~(ra & rb);
            4'h5: lf = ~rb;
            4'h6: lf = ra ^ rb;
            4'h7: lf = ra & ~rb;
            4'h8: lf = ~ra | rb;
            4'h9: lf = ~(ra ^ rb);
            4'hA: lf = rb;
            4'hB: lf = ra & rb;
            4'hC: lf = '1;
            4'hD: lf = ra | ~rb;
            4'hE: lf = ra | rb;
            default: lf = ra;
        endcase
        r.f     = rm ? lf : sum[W-1:0];
        r.c_out = ~sum[W];
        r.eq    = (r.f == {W{1'b1}});
        return r;
    endfunction

    // Issue one operation and follow it to completion. Latency counts edges
    // from the accepting edge to the first sample with done high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tc,
                          output res_t got, output int lat, output int busy_n,
                          output int done_n);
        bit seen;
        seen   = 1'b0;
        got    = '0;
        lat    = 0;
        busy_n = 0;
        done_n = 0;
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom()); b = 16'($urandom());
        s = 4'($urandom()); m = 1'($urandom()); c_in = 1'($urandom());
        for (int i = 1; i <= 20; i++) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            if (done) begin
                done_n++;
                if (!seen) begin
                    seen = 1'b1;
                    lat  = i;
                    got  = {f, c_out, a_eq_b};
                end
            end
            if (!busy) break;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: done never seen, required within 20 cycles");
        end
    endtask

    task automatic test_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [3:0] ts, input logic tm, input logic tc);
        res_t exp;
        res_t got;
        int   lat;
        int   bn;
        int   dn;
        exp = ref_model(ta, tb, ts, tm, tc);
        run_op(ta, tb, ts, tm, tc, got, lat, bn, dn);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s_result: a=%h b=%h s=%b m=%b c_in=%b got f=%h c_out=%b a_eq_b=%b, expected f=%h c_out=%b a_eq_b=%b",
                     name, ta, tb, ts, tm, tc, got.f, got.c_out, got.eq, exp.f, exp.c_out, exp.eq);
        end
        vectors++;
        if (lat !== NIB) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d, expected %0d", name, lat, NIB);
        end
        vectors++;
        if (bn !== NIB + 1) begin
            miscompares++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, bn, NIB + 1);
        end
        vectors++;
        if (dn !== 1) begin
            miscompares++;
            $display("FAIL %s_done_pulses: got %0d, expected 1", name, dn);
        end
        vectors++;
        if ({f, c_out, a_eq_b} !== exp) begin
            miscompares++;
            $display("FAIL %s_held: got f=%h c_out=%b a_eq_b=%b, expected f=%h c_out=%b a_eq_b=%b",
                     name, f, c_out, a_eq_b, exp.f, exp.c_out, exp.eq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; c_in = NO_CARRY;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b, expected 0 0", busy, done);
        end
        vectors++;
        if ({f, c_out, a_eq_b} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: f=%h c_out=%b a_eq_b=%b, expected 0000 1 0", f, c_out, a_eq_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        test_op("add",     16'h1234, 16'h0FFF, S_A_PLUS_B,  1'b0, NO_CARRY);
        test_op("wrap",    16'hFFFF, 16'h0001, S_A_PLUS_B,  1'b0, NO_CARRY);
        test_op("eq_hit",  16'h5000, 16'h5000, S_A_MINUS_B, 1'b0, NO_CARRY);
        test_op("eq_miss", 16'h5000, 16'h5001, S_A_MINUS_B, 1'b0, NO_CARRY);
        test_op("ripple",  16'h00FF, 16'h0000, S_A_PLUS_1,  1'b0, CARRY);
        test_op("logic",   16'hA5A5, 16'hFFFF, S_XOR,       1'b1, NO_CARRY);
        test_op("dec",     16'h0000, 16'h1234, S_A_MINUS_1, 1'b0, NO_CARRY);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_op("random", 16'($urandom()), 16'($urandom()), 4'($urandom()),
                    1'($urandom()), 1'($urandom()));
        end
    endtask

    task automatic test_ignored_start();
        res_t exp;
        int   edges;
        bit   seen;
        exp   = ref_model(16'h1111, 16'h2222, S_A_PLUS_B, 1'b0, NO_CARRY);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; s = S_A_PLUS_B; m = 1'b0; c_in = NO_CARRY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 16'hDEAD; b = 16'hBEEF; s = S_XOR; m = 1'b1; c_in = CARRY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 3;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        vectors++;
        if (!seen || edges !== NIB) begin
            miscompares++;
            $display("FAIL ignored_latency: done seen=%b after %0d edges, expected 1 after %0d", seen, edges, NIB);
        end
        vectors++;
        if ({f, c_out, a_eq_b} !== exp) begin
            miscompares++;
            $display("FAIL ignored_result: got f=%h c_out=%b a_eq_b=%b, expected f=%h c_out=%b a_eq_b=%b",
                     f, c_out, a_eq_b, exp.f, exp.c_out, exp.eq);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_no_queue: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_mid_run_reset();
        test_op("pre_reset", 16'hFFFF, 16'h0002, S_A_PLUS_B, 1'b0, NO_CARRY);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; s = S_A_PLUS_B; m = 1'b0; c_in = NO_CARRY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_status: busy=%b done=%b, expected 0 0", busy, done);
        end
        vectors++;
        if ({f, c_out, a_eq_b} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_outputs: f=%h c_out=%b a_eq_b=%b, expected 0000 1 0", f, c_out, a_eq_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: busy=%b, expected 0", busy);
        end
        test_op("post_reset", 16'h4321, 16'h1111, S_A_MINUS_B, 1'b0, CARRY);
    endtask

    // start held high through DONE: the next op is taken at the first edge
    // that samples IDLE, so done pulses are NIBBLES+2 edges apart.
    task automatic test_back_to_back();
        res_t exp1;
        res_t exp2;
        int   d1;
        int   d2;
        exp1 = ref_model(16'h0123, 16'h0456, S_A_PLUS_B, 1'b0, CARRY);
        exp2 = ref_model(16'hF0F0, 16'h3C3C, S_XOR,      1'b1, NO_CARRY);
        d1 = 0;
        d2 = 0;
        @(negedge clk);
        a = 16'h0123; b = 16'h0456; s = S_A_PLUS_B; m = 1'b0; c_in = CARRY; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                d1 = i;
                break;
            end
        end
        vectors++;
        if (d1 !== NIB || {f, c_out, a_eq_b} !== exp1) begin
            miscompares++;
            $display("FAIL b2b_first: done at %0d f=%h c_out=%b a_eq_b=%b, expected %0d f=%h c_out=%b a_eq_b=%b",
                     d1, f, c_out, a_eq_b, NIB, exp1.f, exp1.c_out, exp1.eq);
        end
        a = 16'hF0F0; b = 16'h3C3C; s = S_XOR; m = 1'b1; c_in = NO_CARRY;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                d2 = i;
                break;
            end
        end
        start = 1'b0;
        vectors++;
        if (d2 !== NIB + 2 || {f, c_out, a_eq_b} !== exp2) begin
            miscompares++;
            $display("FAIL b2b_second: gap %0d f=%h c_out=%b a_eq_b=%b, expected %0d f=%h c_out=%b a_eq_b=%b",
                     d2, f, c_out, a_eq_b, NIB + 2, exp2.f, exp2.c_out, exp2.eq);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_mid_run_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
